// File: rtl/pong_video_pkg.sv
// Shared timing defaults, playfield geometry and colour codes for the pong video path.
package pong_video_pkg;

  localparam int unsigned H_ACTIVE_DEF = 640;
  localparam int unsigned H_FP_DEF     = 16;
  localparam int unsigned H_SYNC_DEF   = 96;
  localparam int unsigned H_BP_DEF     = 48;
  localparam int unsigned V_ACTIVE_DEF = 480;
  localparam int unsigned V_FP_DEF     = 10;
  localparam int unsigned V_SYNC_DEF   = 2;
  localparam int unsigned V_BP_DEF     = 33;

  localparam int unsigned PADDLE_W_DEF = 8;
  localparam int unsigned PADDLE_H_DEF = 64;
  localparam int unsigned BALL_SZ_DEF  = 8;

  // Paddles sit PADDLE_MARGIN in from each edge; the net is NET_W wide and centred.
  localparam int unsigned LEFT_PADDLE_X = 16;
  localparam int unsigned PADDLE_MARGIN = 16;
  localparam int unsigned NET_W         = 4;

  typedef enum logic [3:0] {
    PIX_BLACK = 4'd0,
    PIX_WHITE = 4'd1
  } pix_sel_e;

  // 616 at 640 visible pixels with 8-pixel paddles.
  function automatic int unsigned right_paddle_x(input int unsigned h_active,
                                                 input int unsigned paddle_w);
    return h_active - PADDLE_MARGIN - paddle_w;
  endfunction

  // 318 at 640 visible pixels, net spans 318..321.
  function automatic int unsigned net_x_lo(input int unsigned h_active);
    return h_active / 2 - NET_W / 2;
  endfunction

  // 11-bit span test so objects hanging off the far edge never wrap back to 0.
  function automatic logic in_span(input logic [10:0] pos, input logic [10:0] start,
                                   input logic [10:0] size);
    return (pos >= start) && (pos < start + size);
  endfunction

endpackage

// File: rtl/pong_video_timing.sv
// Pixel/line counters plus sync and data-enable generation, registered one clk after the counters.
module pong_video_timing
  import pong_video_pkg::*;
#(
  parameter int unsigned H_ACTIVE = H_ACTIVE_DEF,
  parameter int unsigned H_FP     = H_FP_DEF,
  parameter int unsigned H_SYNC   = H_SYNC_DEF,
  parameter int unsigned H_BP     = H_BP_DEF,
  parameter int unsigned V_ACTIVE = V_ACTIVE_DEF,
  parameter int unsigned V_FP     = V_FP_DEF,
  parameter int unsigned V_SYNC   = V_SYNC_DEF,
  parameter int unsigned V_BP     = V_BP_DEF
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       pixel_en,
  output logic [9:0] hcount,
  output logic [9:0] vcount,
  output logic       visible,
  output logic       shadow_load,
  output logic       hsync,
  output logic       vsync,
  output logic       de,
  output logic       frame_start
);

  localparam int unsigned H_TOTAL = H_ACTIVE + H_FP + H_SYNC + H_BP;
  localparam int unsigned V_TOTAL = V_ACTIVE + V_FP + V_SYNC + V_BP;

  localparam logic [9:0] H_LAST   = 10'(H_TOTAL - 1);
  localparam logic [9:0] V_LAST   = 10'(V_TOTAL - 1);
  localparam logic [9:0] H_VIS    = 10'(H_ACTIVE);
  localparam logic [9:0] V_VIS    = 10'(V_ACTIVE);
  localparam logic [9:0] V_VLAST  = 10'(V_ACTIVE - 1);
  localparam logic [9:0] HS_FIRST = 10'(H_ACTIVE + H_FP);
  localparam logic [9:0] HS_LAST  = 10'(H_ACTIVE + H_FP + H_SYNC - 1);
  localparam logic [9:0] VS_FIRST = 10'(V_ACTIVE + V_FP);
  localparam logic [9:0] VS_LAST  = 10'(V_ACTIVE + V_FP + V_SYNC - 1);

  logic [9:0] hcount_q, hcount_d;
  logic [9:0] vcount_q, vcount_d;
  logic       line_end, frame_end;

  assign hcount      = hcount_q;
  assign vcount      = vcount_q;
  assign line_end    = (hcount_q == H_LAST);
  assign frame_end   = line_end && (vcount_q == V_LAST);
  assign visible     = (hcount_q < H_VIS) && (vcount_q < V_VIS);
  // Last visible pixel to first blanking line: the next frame's positions are latched here.
  assign shadow_load = pixel_en && line_end && (vcount_q == V_VLAST);

  always_comb begin
    hcount_d = hcount_q;
    vcount_d = vcount_q;
    if (pixel_en) begin
      if (line_end) begin
        hcount_d = '0;
        vcount_d = (vcount_q == V_LAST) ? '0 : vcount_q + 10'd1;
      end else begin
        hcount_d = hcount_q + 10'd1;
      end
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      hcount_q    <= '0;
      vcount_q    <= '0;
      hsync       <= 1'b1;
      vsync       <= 1'b1;
      de          <= 1'b0;
      frame_start <= 1'b0;
    end else begin
      hcount_q    <= hcount_d;
      vcount_q    <= vcount_d;
      hsync       <= !((hcount_q >= HS_FIRST) && (hcount_q <= HS_LAST));
      vsync       <= !((vcount_q >= VS_FIRST) && (vcount_q <= VS_LAST));
      de          <= visible;
      frame_start <= pixel_en && frame_end;
    end
  end

endmodule

// File: rtl/pong_pixel_select.sv
// Pong playfield renderer: per-pixel hit tests against frame-latched object positions.
module pong_pixel_select
  import pong_video_pkg::*;
#(
  parameter int unsigned H_ACTIVE = H_ACTIVE_DEF,
  parameter int unsigned H_FP     = H_FP_DEF,
  parameter int unsigned H_SYNC   = H_SYNC_DEF,
  parameter int unsigned H_BP     = H_BP_DEF,
  parameter int unsigned V_ACTIVE = V_ACTIVE_DEF,
  parameter int unsigned V_FP     = V_FP_DEF,
  parameter int unsigned V_SYNC   = V_SYNC_DEF,
  parameter int unsigned V_BP     = V_BP_DEF,
  parameter int unsigned PADDLE_W = PADDLE_W_DEF,
  parameter int unsigned PADDLE_H = PADDLE_H_DEF,
  parameter int unsigned BALL_SZ  = BALL_SZ_DEF
) (
  input  logic       clk_100MHz,
  input  logic       Reset,
  input  logic       PixelEn,
  input  logic [9:0] LeftPaddleY,
  input  logic [9:0] RightPaddleY,
  input  logic [9:0] BallX,
  input  logic [9:0] BallY,
  output logic [3:0] PixelSel,
  output logic       HSync,
  output logic       VSync,
  output logic       DataEnable,
  output logic       FrameStart
);

  localparam logic [10:0] LPX  = 11'(LEFT_PADDLE_X);
  localparam logic [10:0] RPX  = 11'(right_paddle_x(H_ACTIVE, PADDLE_W));
  localparam logic [10:0] NETX = 11'(net_x_lo(H_ACTIVE));
  localparam logic [10:0] PW   = 11'(PADDLE_W);
  localparam logic [10:0] PH   = 11'(PADDLE_H);
  localparam logic [10:0] BS   = 11'(BALL_SZ);
  localparam logic [10:0] NW   = 11'(NET_W);

  logic [9:0]  hcount, vcount;
  logic        visible, shadow_load;
  logic        hsync_s1, vsync_s1, de_s1;
  logic [9:0]  lpy_q, rpy_q, bx_q, by_q;
  logic [10:0] x, y;
  logic        hit_left, hit_right, hit_ball, hit_net;
  pix_sel_e    pix_d;

  pong_video_timing #(
    .H_ACTIVE (H_ACTIVE),
    .H_FP     (H_FP),
    .H_SYNC   (H_SYNC),
    .H_BP     (H_BP),
    .V_ACTIVE (V_ACTIVE),
    .V_FP     (V_FP),
    .V_SYNC   (V_SYNC),
    .V_BP     (V_BP)
  ) u_timing (
    .clk         (clk_100MHz),
    .rst         (Reset),
    .pixel_en    (PixelEn),
    .hcount      (hcount),
    .vcount      (vcount),
    .visible     (visible),
    .shadow_load (shadow_load),
    .hsync       (hsync_s1),
    .vsync       (vsync_s1),
    .de          (de_s1),
    .frame_start (FrameStart)
  );

  assign x = {1'b0, hcount};
  assign y = {1'b0, vcount};

  always_comb begin
    hit_left  = in_span(x, LPX, PW) && in_span(y, {1'b0, lpy_q}, PH);
    hit_right = in_span(x, RPX, PW) && in_span(y, {1'b0, rpy_q}, PH);
    hit_ball  = in_span(x, {1'b0, bx_q}, BS) && in_span(y, {1'b0, by_q}, BS);
    // Dashed net: 16 lines on, 16 lines off.
    hit_net   = in_span(x, NETX, NW) && !vcount[4];
    pix_d     = PIX_BLACK;
    if (visible && (hit_left || hit_right || hit_ball || hit_net)) begin
      pix_d = PIX_WHITE;
    end
  end

  always_ff @(posedge clk_100MHz or posedge Reset) begin
    if (Reset) begin
      lpy_q      <= '0;
      rpy_q      <= '0;
      bx_q       <= '0;
      by_q       <= '0;
      PixelSel   <= PIX_BLACK;
      HSync      <= 1'b1;
      VSync      <= 1'b1;
      DataEnable <= 1'b0;
    end else begin
      if (shadow_load) begin
        lpy_q <= LeftPaddleY;
        rpy_q <= RightPaddleY;
        bx_q  <= BallX;
        by_q  <= BallY;
      end
      PixelSel   <= pix_d;
      // Extra stage lines the syncs up with the registered colour ROM output.
      HSync      <= hsync_s1;
      VSync      <= vsync_s1;
      DataEnable <= de_s1;
    end
  end

endmodule

// File: tb/tb_pong_pixel_select.sv
// Bench for pong_pixel_select on a shrunken 80x55 raster: per-clock model compare plus pinned pixels.
module tb_pong_pixel_select;

  localparam int HA = 64, HFP = 4, HSW = 8, HBP = 4;
  localparam int VA = 48, VFP = 2, VSW = 2, VBP = 3;
  localparam int PW = 8, PH = 16, BS = 4;
  localparam int HT = HA + HFP + HSW + HBP;  // 80
  localparam int VT = VA + VFP + VSW + VBP;  // 55
  localparam int LPX = 16, RPX = 40, NETX = 30;

  logic       clk_100MHz;
  logic       Reset;
  logic       PixelEn;
  logic [9:0] LeftPaddleY, RightPaddleY, BallX, BallY;
  logic [3:0] PixelSel;
  logic       HSync, VSync, DataEnable, FrameStart;

  pong_pixel_select #(
    .H_ACTIVE (HA), .H_FP (HFP), .H_SYNC (HSW), .H_BP (HBP),
    .V_ACTIVE (VA), .V_FP (VFP), .V_SYNC (VSW), .V_BP (VBP),
    .PADDLE_W (PW), .PADDLE_H (PH), .BALL_SZ (BS)
  ) dut (
    .clk_100MHz   (clk_100MHz),
    .Reset        (Reset),
    .PixelEn      (PixelEn),
    .LeftPaddleY  (LeftPaddleY),
    .RightPaddleY (RightPaddleY),
    .BallX        (BallX),
    .BallY        (BallY),
    .PixelSel     (PixelSel),
    .HSync        (HSync),
    .VSync        (VSync),
    .DataEnable   (DataEnable),
    .FrameStart   (FrameStart)
  );

  initial clk_100MHz = 1'b0;
  always #5 clk_100MHz = ~clk_100MHz;

  int n_pass = 0;
  int n_total = 0;

  task automatic check(input string name, input int act, input int exp);
    n_total++;
    if (act == exp) n_pass++;
    else $display("FAIL %s: got %0d, expected %0d (t=%0t)", name, act, exp, $time);
  endtask

  function automatic logic white(input int x, input int y, input int lpy, input int rpy,
                                 input int bx, input int by);
    logic hit;
    hit = (x >= LPX && x < LPX + PW && y >= lpy && y < lpy + PH) ||
          (x >= RPX && x < RPX + PW && y >= rpy && y < rpy + PH) ||
          (x >= bx && x < bx + BS && y >= by && y < by + BS) ||
          (x >= NETX && x < NETX + 4 && (y / 16) % 2 == 0);
    return hit && x < HA && y < VA;
  endfunction

  // Model: raster position, latched positions, and expected outputs after each edge.
  int   m_h, m_v, p_h, p_v;
  bit   p_vld;
  int   sh_l, sh_r, sh_bx, sh_by;
  logic e_sel, e_hs, e_vs, e_de, e_fs;

  always @(posedge clk_100MHz or posedge Reset) begin
    if (Reset) begin
      m_h <= 0; m_v <= 0; p_h <= 0; p_v <= 0; p_vld <= 1'b0;
      sh_l <= 0; sh_r <= 0; sh_bx <= 0; sh_by <= 0;
      e_sel <= 1'b0; e_hs <= 1'b1; e_vs <= 1'b1; e_de <= 1'b0; e_fs <= 1'b0;
    end else begin
      e_sel <= white(m_h, m_v, sh_l, sh_r, sh_bx, sh_by);
      e_hs  <= p_vld ? !(p_h >= HA + HFP && p_h < HA + HFP + HSW) : 1'b1;
      e_vs  <= p_vld ? !(p_v >= VA + VFP && p_v < VA + VFP + VSW) : 1'b1;
      e_de  <= p_vld && p_h < HA && p_v < VA;
      e_fs  <= PixelEn && m_h == HT - 1 && m_v == VT - 1;
      p_h <= m_h; p_v <= m_v; p_vld <= 1'b1;
      if (PixelEn) begin
        if (m_h == HT - 1 && m_v == VA - 1) begin
          sh_l <= int'(LeftPaddleY); sh_r <= int'(RightPaddleY);
          sh_bx <= int'(BallX); sh_by <= int'(BallY);
        end
        m_h <= (m_h + 1) % HT;
        if (m_h == HT - 1) m_v <= (m_v + 1) % VT;
      end
    end
  end

  logic seen [VA][HA];
  int   de_cnt = 0, hs_cnt = 0, vs_cnt = 0, fs_cnt = 0;

  always @(negedge clk_100MHz) begin
    check("PixelSel", int'(PixelSel), int'(e_sel));
    check("HSync", int'(HSync), int'(e_hs));
    check("VSync", int'(VSync), int'(e_vs));
    check("DataEnable", int'(DataEnable), int'(e_de));
    check("FrameStart", int'(FrameStart), int'(e_fs));
    if (p_vld && p_h < HA && p_v < VA) seen[p_v][p_h] <= PixelSel[0];
    de_cnt <= de_cnt + int'(DataEnable);
    hs_cnt <= hs_cnt + int'(!HSync);
    vs_cnt <= vs_cnt + int'(!VSync);
    fs_cnt <= fs_cnt + int'(FrameStart);
  end

  task automatic run(input int n, input int period);
    for (int i = 0; i < n; i++) begin
      PixelEn = 1'b1;
      @(posedge clk_100MHz); #1;
      PixelEn = 1'b0;
      repeat (period - 1) begin @(posedge clk_100MHz); #1; end
    end
  endtask

  task automatic idle(input int n);
    repeat (n) begin @(posedge clk_100MHz); #1; end
  endtask

  task automatic pix(input string name, input int y, input int x, input int exp);
    check(name, int'(seen[y][x]), exp);
  endtask

  task automatic set_pos(input int lpy, input int rpy, input int bx, input int by);
    LeftPaddleY = 10'(lpy); RightPaddleY = 10'(rpy); BallX = 10'(bx); BallY = 10'(by);
  endtask

  int de0, hs0, vs0, fs0;

  initial begin
    Reset = 1'b1;
    PixelEn = 1'b0;
    set_pos(10, 30, 50, 20);
    idle(3);
    Reset = 1'b0;

    // Frame 0 runs on zeroed positions; A latched at its visible end.
    run(3840, 1);
    run(4399, 1);
    idle(3);
    pix("lpad_top_left", 10, 16, 1);
    pix("lpad_bot_right", 25, 23, 1);
    pix("lpad_right_of", 10, 24, 0);
    pix("lpad_below", 26, 16, 0);
    pix("lpad_above", 9, 16, 0);
    pix("net_row0", 0, 30, 1);
    pix("net_gap_row16", 16, 31, 0);
    pix("net_row32", 32, 33, 1);
    pix("net_right_of", 31, 34, 0);
    pix("rpad_top", 30, 40, 1);
    pix("rpad_bot", 45, 47, 1);
    pix("rpad_below", 46, 40, 0);
    pix("ball_tl", 20, 50, 1);
    pix("ball_br", 23, 53, 1);
    pix("ball_below", 24, 50, 0);
    pix("ball_right", 20, 54, 0);

    // Ball in the bottom-right corner: clipped at the visible edge, not wrapped to x 0..3.
    set_pos(10, 30, 60, 44);
    run(1, 1);
    run(4399, 1);
    idle(3);
    pix("clip_corner", 47, 63, 1);
    pix("clip_ball_tl", 44, 60, 1);
    pix("clip_above", 43, 63, 0);
    for (int yy = 44; yy < 48; yy++)
      for (int xx = 0; xx < 4; xx++) pix("clip_no_wrap", yy, xx, 0);

    // Positions near 1023: sums exceed 10 bits and must not wrap to the top/left.
    set_pos(1020, 40, 1022, 1022);
    run(1, 1);
    run(4399, 1);
    idle(3);
    pix("wrap_ball_00", 0, 0, 0);
    pix("wrap_ball_11", 1, 1, 0);
    pix("wrap_lpad_0", 0, 16, 0);
    pix("wrap_lpad_11", 11, 16, 0);
    pix("rpad_clip_top", 40, 47, 1);
    pix("rpad_clip_last", 47, 40, 1);
    pix("rpad_clip_above", 39, 40, 0);
    pix("net_still", 0, 30, 1);

    // Full frame at one pixel per 4 clks, with BallY moved mid-frame.
    set_pos(10, 30, 50, 10);
    run(1, 1);
    idle(3);
    de0 = de_cnt; hs0 = hs_cnt; vs0 = vs_cnt; fs0 = fs_cnt;
    run(2560, 4);
    BallY = 10'd30;
    run(1839, 4);
    pix("mid_ball_old_y", 10, 50, 1);
    pix("mid_ball_old_br", 13, 53, 1);
    pix("mid_ball_not_new", 30, 50, 0);
    run(1, 4);
    check("frame_de_clks", de_cnt - de0, HA * VA * 4);
    check("frame_hsync_low_clks", hs_cnt - hs0, HSW * VT * 4);
    check("frame_vsync_low_clks", vs_cnt - vs0, VSW * HT * 4);
    check("frame_start_count", fs_cnt - fs0, 1);

    run(4399, 1);
    idle(3);
    pix("next_ball_new_y", 30, 50, 1);
    pix("next_ball_old_gone", 10, 50, 0);
    run(1, 1);

    // Mid-line reset while a visible pixel is on the outputs.
    run(600, 1);
    idle(3);
    check("pre_reset_de", int'(DataEnable), 1);
    Reset = 1'b1;
    #1;
    check("rst_pixelsel", int'(PixelSel), 0);
    check("rst_hsync", int'(HSync), 1);
    check("rst_vsync", int'(VSync), 1);
    check("rst_de", int'(DataEnable), 0);
    check("rst_framestart", int'(FrameStart), 0);
    idle(3);
    Reset = 1'b0;
    fs0 = fs_cnt;
    idle(2);
    check("post_rst_de_at_origin", int'(DataEnable), 1);
    check("post_rst_ball_at_origin", int'(PixelSel), 1);
    run(4399, 1);
    idle(2);
    check("no_fs_aborted_frame", fs_cnt - fs0, 0);
    run(1, 1);
    idle(2);
    check("fs_after_restart", fs_cnt - fs0, 1);

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule

// File: doc/pong_pixel_select.md
PONG_PIXEL_SELECT -- requirements
Module: pong_pixel_select

Interface
REQ-001 Parameter H_ACTIVE, default 640: visible pixels per line.
REQ-002 Parameter H_FP, default 16; H_SYNC, default 96; H_BP, default 48: horizontal front porch, sync and back porch (H total 800).
REQ-003 Parameter V_ACTIVE, default 480; V_FP, default 10; V_SYNC, default 2; V_BP, default 33: vertical timing (V total 525).
REQ-004 Parameter PADDLE_W, default 8; PADDLE_H, default 64; BALL_SZ, default 8: object sizes in pixels.
REQ-005 clk_100MHz  in  1  single system clock; all logic on rising edge.
REQ-006 Reset  in  1  asynchronous, active-high reset.
REQ-007 PixelEn  in  1  pixel-rate enable; one clk_100MHz-cycle pulse per pixel.
REQ-008 LeftPaddleY  in  10  top row of left paddle.
REQ-009 RightPaddleY  in  10  top row of right paddle.
REQ-010 BallX, BallY  in  10 each  top-left corner of ball.
REQ-011 PixelSel  out  4  colour code to the pixel colour ROM (0 black, 1 white).
REQ-012 HSync, VSync  out  1 each  active-low syncs.
REQ-013 DataEnable  out  1  high during visible pixels.
REQ-014 FrameStart  out  1  one-clk pulse at start of each frame.

Function
REQ-015 HCount (10 b) shall advance only on PixelEn cycles, wrapping 799->0; at that wrap VCount shall advance, wrapping 524->0.
REQ-016 With PixelEn low, counters and all outputs shall hold.
REQ-017 Visible region: HCount < H_ACTIVE and VCount < V_ACTIVE.
REQ-018 HSync low for HCount in [656,751]; VSync low for VCount in [490,491]; high otherwise.
REQ-019 Position inputs shall be sampled into shadow registers only on the PixelEn cycle advancing (799,479)->(0,480); mid-frame input changes shall not alter the displayed frame.
REQ-020 Hit tests use shadow registers, 11-bit sums (no wrap): left paddle x in [16,16+PADDLE_W-1], y in [LPY,LPY+PADDLE_H-1]; right paddle x in [616,616+PADDLE_W-1]; ball x in [BX,BX+BALL_SZ-1], y in [BY,BY+BALL_SZ-1]; net x in [318,321] and VCount[4]==0.
REQ-021 Objects extending past visible edges shall be clipped, never wrapped.
REQ-022 PixelSel shall be registered: 1 if visible and any hit, else 0, one clk after the counter value it reflects; codes 2-15 never emitted.
REQ-023 HSync, VSync, DataEnable shall lag PixelSel by exactly one further clk, aligning with the registered colour ROM output.
REQ-024 FrameStart shall pulse one clk on the cycle counters become (0,0).

Reset
REQ-025 Reset shall force HCount=0, VCount=0, shadow registers=0, PixelSel=0, HSync=1, VSync=1, DataEnable=0, FrameStart=0, immediately and independent of clk.
REQ-026 Reset mid-frame shall abort the frame; after release the first PixelEn begins at (0,0) with no FrameStart for the aborted frame.

Structure
REQ-027 Package pong_video_pkg shall hold timing constants, object geometry constants (paddle x columns, net columns) and PixelSel codes PIX_BLACK=0, PIX_WHITE=1.
REQ-028 Counters and sync/DE generation shall be sub-module pong_video_timing; hit tests and output pipeline stay in pong_pixel_select.

Verification
REQ-029 Reset asserted mid-line -> all outputs at reset values same cycle; first PixelEn after release -> HCount=0, VCount=0.
REQ-030 PixelEn every 4th clk, one full frame -> 800x525 pixel steps, HSync low 96 pixels/line, VSync low lines 490-491, DataEnable high 640x480 pixels, one FrameStart.
REQ-031 LeftPaddleY=100 -> PixelSel=1 at x 16..23, y 100..163; 0 at (24,100) and (16,164).
REQ-032 BallX=636, BallY=476 -> white at (639,479), no white at x 0..3 of any row from the ball.
REQ-033 BallY changed 200->300 while VCount=250 -> ball stays at y 200 until next frame, moves to 300 after (799,479) boundary.
REQ-034 Check alignment -> HSync/DataEnable transitions occur exactly one clk after matching PixelSel transition; PixelSel never outside {0,1}.
